// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// ex_stage : MIPS execute stage - operand forwarding, ALU, branch resolution
//            and the EX/MEM pipeline register.
// Revision : 1.0
// ============================================================================
module ex_stage (
  input  logic         clk,
  input  logic         reset_b,
  input  logic [229:0] ID_EX,
  input  logic         MEM_WB_RegWrite,
  input  logic [4:0]   MEM_WB_Rd,
  input  logic [31:0]  MEM_WB_RdData,
  output logic [4:0]   ID_EX_Rt,
  output logic         ID_EX_MemRead,
  output logic         PCSrcB,
  output logic [31:0]  branch_target,
  output logic         branch_flush,
  output logic [105:0] EX_MEM,
  output logic [4:0]   EX_MEM_Rd,
  output logic [31:0]  EX_MEM_RdData,
  output logic         EX_MEM_RegWrite
);

  localparam logic [1:0] GRP_ARITH = 2'b00;
  localparam logic [1:0] GRP_LOGIC = 2'b01;
  localparam logic [1:0] GRP_SHIFT = 2'b10;
  localparam logic [1:0] GRP_CMP   = 2'b11;

  localparam logic [3:0] LOG_AND   = 4'b1000;
  localparam logic [3:0] LOG_OR    = 4'b1110;
  localparam logic [3:0] LOG_XOR   = 4'b0110;
  localparam logic [3:0] LOG_NOR   = 4'b0001;
  localparam logic [3:0] LOG_A     = 4'b1010;

  localparam logic [1:0] SH_SLL    = 2'b00;
  localparam logic [1:0] SH_SRL    = 2'b01;
  localparam logic [1:0] SH_SRA    = 2'b11;

  localparam logic [2:0] CMP_NE    = 3'b000;
  localparam logic [2:0] CMP_EQ    = 3'b001;
  localparam logic [2:0] CMP_LT    = 3'b010;
  localparam logic [2:0] CMP_LTZ   = 3'b101;
  localparam logic [2:0] CMP_LEZ   = 3'b110;
  localparam logic [2:0] CMP_GTZ   = 3'b111;

  localparam logic [1:0] DST_RD    = 2'b00;
  localparam logic [1:0] DST_RT    = 2'b01;
  localparam logic [1:0] DST_RA    = 2'b10;
  localparam logic [1:0] DST_K0    = 2'b11;

  localparam logic [1:0] M2R_PC    = 2'b10;

  // Decode bundle fields
  logic [31:0] rs_data, rt_data, branch_address, lu_data, pc_plus4, imm32;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  alu_fun;
  logic [1:0]  mem_to_reg, reg_dst;
  logic        alu_src1, alu_src2, sign, mem_read, mem_write, reg_write;
  logic        lu_op, branch;

  assign rs_data        = ID_EX[31:0];
  assign rt_data        = ID_EX[63:32];
  assign rs             = ID_EX[68:64];
  assign rt             = ID_EX[73:69];
  assign rd             = ID_EX[78:74];
  assign sign           = ID_EX[79];
  assign alu_fun        = ID_EX[85:80];
  assign alu_src2       = ID_EX[86];
  assign alu_src1       = ID_EX[87];
  assign branch_address = ID_EX[119:88];
  assign mem_write      = ID_EX[120];
  assign mem_read       = ID_EX[121];
  assign reg_write      = ID_EX[122];
  assign mem_to_reg     = ID_EX[124:123];
  assign lu_data        = ID_EX[156:125];
  assign lu_op          = ID_EX[157];
  assign pc_plus4       = ID_EX[189:158];
  assign shamt          = ID_EX[194:190];
  assign imm32          = ID_EX[226:195];
  assign branch         = ID_EX[227];
  assign reg_dst        = ID_EX[229:228];

  logic [105:0] ex_mem_q, ex_mem_d;
  logic [31:0]  exm_rd_data;
  logic [4:0]   exm_write_reg;
  logic         exm_reg_write;

  assign exm_rd_data   = ex_mem_q[31:0];
  assign exm_write_reg = ex_mem_q[68:64];
  assign exm_reg_write = ex_mem_q[73];

  // Forwarding: the younger EX/MEM result takes priority over MEM/WB; $0 never forwards
  logic [31:0] fwd_rs, fwd_rt;

  always_comb begin
    fwd_rs = rs_data;
    if (exm_reg_write && (exm_write_reg == rs) && (rs != 5'd0)) begin
      fwd_rs = exm_rd_data;
    end else if (MEM_WB_RegWrite && (MEM_WB_Rd == rs) && (rs != 5'd0)) begin
      fwd_rs = MEM_WB_RdData;
    end
  end

  always_comb begin
    fwd_rt = rt_data;
    if (exm_reg_write && (exm_write_reg == rt) && (rt != 5'd0)) begin
      fwd_rt = exm_rd_data;
    end else if (MEM_WB_RegWrite && (MEM_WB_Rd == rt) && (rt != 5'd0)) begin
      fwd_rt = MEM_WB_RdData;
    end
  end

  logic [31:0] op_a, op_b;

  assign op_a = alu_src1 ? {27'b0, shamt} : fwd_rs;
  assign op_b = alu_src2 ? imm32 : fwd_rt;

  logic        cmp_flag;
  logic [31:0] alu_out;

  always_comb begin
    cmp_flag = 1'b0;
    case (alu_fun[3:1])
      CMP_NE:  cmp_flag = (op_a != op_b);
      CMP_EQ:  cmp_flag = (op_a == op_b);
      CMP_LT:  cmp_flag = sign ? ($signed(op_a) < $signed(op_b)) : (op_a < op_b);
      CMP_LEZ: cmp_flag = op_a[31] || (op_a == 32'd0);
      CMP_LTZ: cmp_flag = op_a[31];
      CMP_GTZ: cmp_flag = !op_a[31] && (op_a != 32'd0);
      default: cmp_flag = 1'b0;
    endcase
  end

  always_comb begin
    alu_out = 32'd0;
    case (alu_fun[5:4])
      GRP_ARITH: alu_out = alu_fun[0] ? (op_a - op_b) : (op_a + op_b);
      GRP_LOGIC: begin
        case (alu_fun[3:0])
          LOG_AND: alu_out = op_a & op_b;
          LOG_OR:  alu_out = op_a | op_b;
          LOG_XOR: alu_out = op_a ^ op_b;
          LOG_NOR: alu_out = ~(op_a | op_b);
          LOG_A:   alu_out = op_a;
          default: alu_out = 32'd0;
        endcase
      end
      GRP_SHIFT: begin
        case (alu_fun[1:0])
          SH_SLL:  alu_out = op_b << op_a[4:0];
          SH_SRL:  alu_out = op_b >> op_a[4:0];
          SH_SRA:  alu_out = $unsigned($signed(op_b) >>> op_a[4:0]);
          default: alu_out = 32'd0;
        endcase
      end
      GRP_CMP:   alu_out = {31'b0, cmp_flag};
      default:   alu_out = 32'd0;
    endcase
  end

  logic [4:0]  write_reg;
  logic [31:0] rd_data;

  always_comb begin
    write_reg = rd;
    case (reg_dst)
      DST_RD:  write_reg = rd;
      DST_RT:  write_reg = rt;
      DST_RA:  write_reg = 5'd31;
      DST_K0:  write_reg = 5'd26;
      default: write_reg = rd;
    endcase
  end

  // Loads leave ALU-derived data here; the real load value is selected in MEM
  always_comb begin
    rd_data = alu_out;
    if (lu_op) begin
      rd_data = lu_data;
    end else if (mem_to_reg == M2R_PC) begin
      rd_data = pc_plus4;
    end
  end

  always_comb begin
    ex_mem_d = {alu_out, reg_write, mem_to_reg, mem_read, mem_write,
                write_reg, fwd_rt, rd_data};
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      ex_mem_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
    end
  end

  assign PCSrcB          = branch & alu_out[0];
  assign branch_flush    = PCSrcB;
  assign branch_target   = branch_address;
  assign ID_EX_Rt        = rt;
  assign ID_EX_MemRead   = mem_read;
  assign EX_MEM          = ex_mem_q;
  assign EX_MEM_Rd       = exm_write_reg;
  assign EX_MEM_RdData   = exm_rd_data;
  assign EX_MEM_RegWrite = exm_reg_write;

endmodule
`default_nettype wire

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline. Consumes the 230-bit ID/EX bundle and applies operand forwarding from its own EX/MEM register and from MEM/WB. Runs the ALU, resolves conditional branches and registers results into the EX/MEM bundle for the memory stage. It also returns the hazard-detection, forwarding and branch-flush signals that the decode stage needs.

## Interface
- No parameters; all widths fixed.
- clk  in  1  pipeline clock, rising edge.
- reset_b  in  1  reset; asynchronous, active-low.
- ID_EX  in  230  decode bundle, laid out as follows:
  - [31:0] RsData, [63:32] RtData
  - [68:64] Rs, [73:69] Rt, [78:74] Rd
  - [87] ALUSrc1, [86] ALUSrc2, [85:80] ALUFun, [79] Sign
  - [119:88] branch_address
  - [121] MemRead, [120] MemWrite
  - [124:123] MemToReg, [122] RegWrite
  - [157] LUOp, [156:125] LUData
  - [189:158] PC_Plus4, [194:190] Shamt, [226:195] Imm32
  - [227] Branch, [229:228] RegDst
- MEM_WB_RegWrite  in  1  writeback-stage write enable.
- MEM_WB_Rd  in  5  writeback-stage destination register.
- MEM_WB_RdData  in  32  writeback-stage result.
- ID_EX_Rt  out  5  ID_EX[73:69], combinational; feeds load-use hazard detection.
- ID_EX_MemRead  out  1  ID_EX[121], combinational.
- PCSrcB  out  1  branch taken, combinational.
- branch_target  out  32  ID_EX[119:88], combinational.
- branch_flush  out  1  equals PCSrcB; drives the decode-stage ID_Flush and the IF flush.
- EX_MEM  out  106  registered bundle, laid out as follows:
  - [31:0] RdData, [63:32] StoreData, [68:64] WriteReg
  - [69] MemWrite, [70] MemRead, [72:71] MemToReg, [73] RegWrite
  - [105:74] ALUOut
- EX_MEM_Rd  out  5  EX_MEM[68:64]; forwarding to decode.
- EX_MEM_RdData  out  32  EX_MEM[31:0].
- EX_MEM_RegWrite  out  1  EX_MEM[73].

## Operation
- **Forwarding, per source operand (Rs, Rt):**
  - If EX_MEM[73] and EX_MEM[68:64]==reg and reg!=0, take EX_MEM[31:0].
  - Else if MEM_WB_RegWrite and MEM_WB_Rd==reg and reg!=0, take MEM_WB_RdData.
  - Else take the bundle data.
  - EX/MEM has priority over MEM/WB.
- **ALU operands:**
  - A = ALUSrc1 ? {27'b0,Shamt} : fwdRs.
  - B = ALUSrc2 ? Imm32 : fwdRt.
- **ALUFun[5:4]=00, add/sub:** ALUFun[0]=1 gives A−B, else A+B. Result wraps mod 2^32; overflow is not trapped.
- **ALUFun[5:4]=01, logic, on ALUFun[3:0]:**
  - 1000 AND, 1110 OR, 0110 XOR, 0001 NOR, 1010 pass A.
  - Any other code gives 0.
- **ALUFun[5:4]=10, shift B by A[4:0], on ALUFun[1:0]:** 00 SLL, 01 SRL, 11 SRA, 10 gives 0.
- **ALUFun[5:4]=11, compare, result {31'b0,flag}; flag by ALUFun[3:1]:**
  - 001 A==B, 000 A!=B.
  - 010 A<B: signed when Sign=1, unsigned when Sign=0.
  - 110 A<=0, 101 A<0, 111 A>0, all signed.
  - Any other code gives 0.
- **Branch:** PCSrcB = ID_EX[227] & ALUOut[0].
- **Write register by RegDst:** 00 Rd, 01 Rt, 10 5'd31, 11 5'd26.
- **RdData:**
  - LUOp ? LUData : (MemToReg==2'b10 ? PC_Plus4 : ALUOut).
  - Loads are resolved in MEM.
- **StoreData** = fwdRt (forwarded, not the Imm-selected B).
- **All-zero ID_EX (bubble/flush)** yields an all-zero EX_MEM: a NOP with no writes. This holds because decoded control bits are zero.

## Timing
- EX_MEM resets to 106'b0 asynchronously on reset_b low; its slice outputs are therefore 0.
- Combinational outputs follow ID_EX, which is 0 in reset, so PCSrcB=0 and branch_flush=0.
- Latency is 1 cycle: ID_EX presented in cycle n appears on EX_MEM after the posedge ending cycle n.
- EX_MEM updates every cycle; there is no stall input. Decode-stage bubbles arrive as zeroed ID_EX.
- Branch resolution:
  - PCSrcB is valid within cycle n.
  - Decode zeroes the ID_EX produced at that edge.
  - The branch instruction itself still enters EX_MEM with RegWrite=0 and MemWrite=0 from its decode.
- Forwarding is combinational within the cycle.
  - A load immediately followed by a user is prevented upstream by the bubble.
  - EX_MEM_RdData for a load holds ALUOut-derived data, and decode must not use it. This is guaranteed by the bubble.
- Simultaneous EX/MEM and MEM/WB match: the EX/MEM value wins.
- Reset mid-operation: EX_MEM clears immediately, without waiting for a clock edge.

## Test plan
- **Reset:** hold reset_b=0 with a non-zero ID_EX.
  - EX_MEM==0 without a clock edge.
  - PCSrcB follows ID_EX combinationally.
- **add $3,$1,$2:** RsData=5, RtData=7, ALUFun=000000, RegDst=00, Rd=3, RegWrite=1.
  - Next edge: ALUOut=12, RdData=12, WriteReg=3, RegWrite=1.
- **Back-to-back forwarding, double match:** prior instruction wrote $1=0x10 (now in EX_MEM); MEM_WB also writes $1=0x99; current instruction sub $4,$1,$0.
  - ALUOut=0x10.
  - The same case with reg $0 as destination gives no forwarding.
- **beq taken:** A=B=0x55, ALUFun=110010, Branch=1, branch_address=0x400.
  - PCSrcB=1, branch_target=0x400, branch_flush=1 in the same cycle.
  - With A!=B: PCSrcB=0.
- **slt signed vs unsigned:** A=0xFFFFFFFF, B=1.
  - Sign=1: ALUOut=1.
  - Sign=0: ALUOut=0.
- **jal / lui / sra:**
  - jal: RegDst=10, MemToReg=10, PC_Plus4=0x104 gives WriteReg=31, RdData=0x104.
  - lui: LUOp=1, LUData=0x12340000 gives RdData=0x12340000.
  - sra: Shamt=4, B=0x80000000 gives 0xF8000000.
